dot_product_accumulator: RTL and testbench

//  - Downstream consumer of the combinational parallel array multiplier: accumulates a

---
 rtl/dpa_pkg.sv | 13 +
 rtl/dpa_acc_add.sv | 25 ++
 rtl/dot_product_accumulator.sv | 105 ++++++++++
 tb/tb_dot_product_accumulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dpa_pkg.sv
// Shared state encoding and default sizing for the dot-product accumulator.
// DPA_SATURATE_EN (see dpa_acc_add) selects saturating rather than wrapping accumulation.
package dpa_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int N_DEF     = 10;
    localparam int ACC_W_DEF = 2 * N_DEF + 8;
    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/dpa_acc_add.sv
// Unsigned ACC_W adder with carry out; with DPA_SATURATE_EN defined the sum clamps to all-ones on carry.
module dpa_acc_add
    import dpa_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] prod,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, acc} + {1'b0, prod};
    assign carry = full[ACC_W];

`ifdef DPA_SATURATE_EN
    // Once clamped, any further non-zero term carries again, so the clamp holds.
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates a programmed number of unsigned multiplier products behind valid/ready handshakes.
// Overflow behaviour (wrap or clamp) is chosen by DPA_SATURATE_EN inside dpa_acc_add.
module dot_product_accumulator
    import dpa_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = 2 * N + 8,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [LEN_W-1:0] remaining;
    logic             xfer;
    logic [ACC_W-1:0] sum;
    logic             carry;

    assign xfer = in_valid && in_ready;

    dpa_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc  (acc_out),
        .prod (ACC_W'(prod)),
        .sum  (sum),
        .carry(carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (xfer && remaining == LEN_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACCUM);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_ACCUM) || (state == ST_DONE);
    end

    // Result and counter registers; acc_out holds through DONE and IDLE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc_out   <= '0;
                        overflow  <= 1'b0;
                        remaining <= len;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        acc_out   <= sum;
                        overflow  <= overflow | carry;
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator (N=10, ACC_W=20); honours DPA_SATURATE_EN.
module tb_dot_product_accumulator;

    localparam int N     = 10;
    localparam int ACC_W = 20;
    localparam int LEN_W = 8;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    dot_product_accumulator #(
        .N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: true sum of all terms, then wrap or clamp at the accumulator width.
    task automatic model(input logic [2*N-1:0] ps[$], output longint exp_acc, output logic exp_ovf);
        longint total = 0;
        foreach (ps[i]) total += longint'(ps[i]);
        exp_ovf = (total > ACC_MAX);
`ifdef DPA_SATURATE_EN
        exp_acc = exp_ovf ? ACC_MAX : total;
`else
        exp_acc = total & ACC_MAX;
`endif
    endtask

    task automatic send(input logic [2*N-1:0] p);
        int n = 0;
        in_valid = 1'b1;
        prod     = p;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        tick();
        in_valid = 1'b0;
        prod     = 20'($urandom);
    endtask

    // One whole operation: start, feed terms with gap idle cycles, hold result, then release.
    task automatic run_op(input string tag, input logic [2*N-1:0] ps[$], input int gap, input int hold);
        longint     exp_acc;
        logic       exp_ovf;
        logic [ACC_W-1:0] held;
        model(ps, exp_acc, exp_ovf);
        start = 1'b1;
        len   = LEN_W'(ps.size());
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (ps.size() == 0) chk({tag, "_zero_in_ready"}, 64'(in_ready), 64'd0);
        foreach (ps[i]) begin
            if (i == ps.size() - 1) chk({tag, "_valid_before_last"}, 64'(out_valid), 64'd0);
            send(ps[i]);
            if (i != ps.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk({tag, "_bubble_ready"}, 64'(in_ready), 64'd1);
                end
            end
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_acc"}, 64'(acc_out), 64'(exp_acc));
        chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        held = acc_out;
        for (int h = 0; h < hold; h++) begin
            start    = (h == 1);
            len      = LEN_W'($urandom);
            in_valid = 1'b1;
            tick();
            chk({tag, "_hold_acc"}, 64'(acc_out), 64'(held));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_idle_acc_kept"}, 64'(acc_out), 64'(exp_acc));
    endtask

    initial begin
        logic [2*N-1:0] q[$];
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; prod = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // in_valid in IDLE must not be taken
        in_valid = 1'b1; prod = 20'd99;
        tick();
        in_valid = 1'b0;
        chk("idle_ignore_acc", 64'(acc_out), 64'd0);

        q = '{20'd15, 20'd300, 20'd65025};
        run_op("basic", q, 0, 0);
        chk("basic_literal", 64'(acc_out), 64'd65340);

        q = {};
        run_op("zero", q, 0, 0);

        q = '{20'd1023, 20'd2};
        run_op("bubble", q, 4, 0);
        chk("bubble_literal", 64'(acc_out), 64'd1025);

        q = '{20'd500, 20'd12};
        run_op("backpressure", q, 1, 5);

        q = '{20'd1046529, 20'd1046529};
        run_op("overflow", q, 0, 0);
`ifdef DPA_SATURATE_EN
        chk("overflow_literal", 64'(acc_out), 64'd1048575);
`else
        chk("overflow_literal", 64'(acc_out), 64'd1044482);
`endif

        // Reset mid-accumulation discards the partial sum
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        send(20'd100);
        send(20'd200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_acc", 64'(acc_out), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        q = '{20'd7};
        run_op("after_rst", q, 0, 0);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = int'($urandom_range(1, 8));
            q = {};
            for (int k = 0; k < n; k++) q.push_back(20'($urandom_range(0, 1046529)));
            run_op("rand", q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
